conv_feed_seq: RTL and testbench
================================

# conv_feed_seq

Transmit-side sequencer for the convolution datapath. On `start` it walks every output neuron of one R×C plane and, per neuron, every kernel tap across all channel groups, issuing one feature-map read address per beat over a valid/ready stream. Tags mark the last tap of each neuron and the last tap of the plane. It is the producer of the exact stream the neuron-ready and plane-ready counters consume: `tap_last` coincides with their neuron boundary (every `CH_GROUPS*KH*KW` beats) and `plane_last` with their plane boundary (every `OUT_ROWS*OUT_COLS` neurons).

## Interface
- `KH`, 5, kernel rows
- `KW`, 5, kernel columns
- `CH_GROUPS`, 1, channel groups, i.e. in_channel/4+1
- `OUT_ROWS`, 28, output plane rows (R)
- `OUT_COLS`, 28, output plane columns (C)
- `ADDR_W`, 16, address and neuron-index width
- `BASE_ADDR`, 0, feature-map base address
- `clk`  in  1  single clock; rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin one plane; honoured only in IDLE
- `feat_ready`  in  1  downstream accepts the current beat
- `feat_valid`  out  1  `feat_addr`/tags are valid
- `feat_addr`  out  ADDR_W  feature-map read address
- `tap_last`  out  1  current beat is the last tap of the neuron
- `plane_last`  out  1  current beat is the last tap of the plane
- `out_addr`  out  ADDR_W  neuron index r*OUT_COLS+c of the current beat
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse after the final beat is accepted

## Operation
- Derived constants: `IN_COLS = OUT_COLS+KW-1`, `IN_ROWS = OUT_ROWS+KH-1`, `TAPS = CH_GROUPS*KH*KW`.
- Address: `BASE_ADDR + g*IN_ROWS*IN_COLS + (r+kr)*IN_COLS + (c+kc)`, truncated modulo 2^ADDR_W. The last address must fit ADDR_W; this is checked at elaboration and a violation is a fatal error.
- Loop nest, outermost first: r, c, g, kr, kc.
- FSM states:
  - IDLE: `feat_valid=0`, all counters 0. `start` moves the FSM to RUN.
  - RUN: `feat_valid=1`. A beat fires when `feat_valid && feat_ready`, and each fire advances kc, which carries into kr, g, c and r.
    - If the fire carries `plane_last`, the FSM goes to DONE.
  - DONE: lasts one cycle with `done=1` and `feat_valid=0`, then returns to IDLE.
- Tags:
  - `tap_last = (g==CH_GROUPS-1 && kr==KH-1 && kc==KW-1)`.
  - `plane_last = tap_last && r==OUT_ROWS-1 && c==OUT_COLS-1`.
- Backpressure: while `feat_valid && !feat_ready`, all outputs hold stable. No beat is skipped or duplicated.
- `start` is ignored in RUN and DONE; it is not queued.
- Reset values: `feat_valid`, `busy`, `done`, `tap_last` and `plane_last` are 0; `feat_addr` and `out_addr` are 0; FSM is in IDLE.
- Reset mid-run aborts immediately. The sequencer stays in IDLE until a fresh `start`.

## Timing
- `start` sampled in IDLE at edge N: from edge N+1, `busy=1`, `feat_valid=1` and `feat_addr` equals the first address.
- All outputs are registered, so there is no combinational path from `feat_ready` to any output.
- Throughput is one beat per cycle while `feat_ready=1`. A plane takes `OUT_ROWS*OUT_COLS*TAPS` fires; with defaults this is 19600.
- Final fire at edge M: `done=1` and `busy=0` during cycle M+1. IDLE follows at M+2, and `start` is accepted from then.

## Configuration
- `CONV_FEED_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort` high in RUN, sampled at an edge, ends the plane: the next cycle has `feat_valid=0` and the FSM in IDLE, with no `done` pulse.
  - `abort` has priority over a simultaneous fire.
- Not defined: the `abort` port is absent and a plane always runs to completion.

## Structure
- Package `conv_feed_pkg` holds:
  - the state enum (`IDLE`, `RUN`, `DONE`);
  - default geometry constants (KH, KW, OUT_ROWS, OUT_COLS, CH_GROUPS);
  - the address-width check function.
- Sub-module `conv_feed_cnt`: parameterised wrapping counter with `inc`, `clr`, value output and `wrap` flag. It is instantiated five times (kc, kr, g, c, r), with each instance's `wrap` chained into the next counter's `inc`.
- Address arithmetic uses row/plane offset registers updated on wrap events, not a multiplier on every beat.

## Test plan
- Reset and defaults, `start` with `feat_ready=1` → first addresses 0,1,2,3,4,32,33,…; 25th beat has address 132, `tap_last=1`, `out_addr=0`; 26th beat has address 1, `out_addr=1`.
- Full plane → exactly 19600 fires; last beat has address 1023, `out_addr=783`, `plane_last=1`; `done` pulses one cycle later; `tap_last` counted 784 times.
- Backpressure: `feat_ready=0` for 3 cycles at beat 10 → address, tags and `out_addr` stay constant; sequence resumes at beat 10 with no gap.
- `start` asserted at beat 50 and again in the DONE cycle → both ignored; a `start` in IDLE afterwards restarts from address 0.
- `rst_n` low at beat 100 → `feat_valid`, `busy` and `done` drop to 0 immediately; after release, outputs stay idle until `start`.
- With `CONV_FEED_ABORT_EN`: `abort` at beat 40 coincident with a fire → `feat_valid=0` the next cycle, no `done`; a following `start` begins at address 0.

Source files
------------

// File: rtl/conv_feed_pkg.sv
// Shared definitions for the convolution feature-read sequencer:
// FSM state encoding, default geometry and the address-width check.
package conv_feed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_KH        = 5;
    localparam int DEF_KW        = 5;
    localparam int DEF_CH_GROUPS = 1;
    localparam int DEF_OUT_ROWS  = 28;
    localparam int DEF_OUT_COLS  = 28;

    // True when the highest feature address of a plane fits in addr_w bits.
    function automatic bit addr_fits(input int kh, input int kw, input int ch_groups,
                                     input int out_rows, input int out_cols,
                                     input int base_addr, input int addr_w);
        longint last;
        last = longint'(base_addr)
             + longint'(ch_groups) * longint'(out_rows + kh - 1) * longint'(out_cols + kw - 1)
             - 1;
        return last < (longint'(1) << addr_w);
    endfunction

endpackage

// File: rtl/conv_feed_cnt.sv
// Wrapping counter 0..MAX-1. 'wrap' is high on the increment that returns
// the count to zero, so it can feed the next counter's 'inc' directly.
module conv_feed_cnt #(
    parameter int MAX = 2,
    parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    assign wrap = inc && (value == W'(MAX - 1));

    // Count on inc, wrap to zero at MAX-1; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/conv_feed_seq.sv
// Feature-map read sequencer: walks r, c, g, kr, kc (outermost first) and
// issues one read address per accepted beat, tagging neuron and plane ends.
// Optional macro CONV_FEED_ABORT_EN adds an 'abort' input that ends a plane
// early without a done pulse.
module conv_feed_seq
    import conv_feed_pkg::*;
#(
    parameter int KH        = DEF_KH,
    parameter int KW        = DEF_KW,
    parameter int CH_GROUPS = DEF_CH_GROUPS,
    parameter int OUT_ROWS  = DEF_OUT_ROWS,
    parameter int OUT_COLS  = DEF_OUT_COLS,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef CONV_FEED_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic              feat_ready,
    output logic              feat_valid,
    output logic [ADDR_W-1:0] feat_addr,
    output logic              tap_last,
    output logic              plane_last,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int IN_COLS   = OUT_COLS + KW - 1;
    localparam int IN_ROWS   = OUT_ROWS + KH - 1;
    // Address deltas applied when the corresponding loop level advances.
    localparam int STEP_ROW  = IN_COLS - (KW - 1);
    localparam int STEP_GRP  = IN_ROWS * IN_COLS - (KH - 1) * IN_COLS - (KW - 1);
    localparam int STEP_NROW = IN_COLS - (OUT_COLS - 1);

    localparam int KC_W = (KW > 1)        ? $clog2(KW)        : 1;
    localparam int KR_W = (KH > 1)        ? $clog2(KH)        : 1;
    localparam int G_W  = (CH_GROUPS > 1) ? $clog2(CH_GROUPS) : 1;
    localparam int C_W  = (OUT_COLS > 1)  ? $clog2(OUT_COLS)  : 1;
    localparam int R_W  = (OUT_ROWS > 1)  ? $clog2(OUT_ROWS)  : 1;

    if (!addr_fits(KH, KW, CH_GROUPS, OUT_ROWS, OUT_COLS, BASE_ADDR, ADDR_W)) begin : g_addr_chk
        $fatal(1, "conv_feed_seq: last feature address does not fit in ADDR_W bits");
    end

    state_t            state;
    logic              abort_i;
    logic              fire;
    logic              cnt_clr;
    logic [ADDR_W-1:0] nbase;
    logic [ADDR_W-1:0] nbase_n;

    logic [KC_W-1:0] kc, kc_n;
    logic [KR_W-1:0] kr, kr_n;
    logic [G_W-1:0]  g,  g_n;
    logic [C_W-1:0]  c,  c_n;
    logic [R_W-1:0]  r,  r_n;
    logic            kc_wrap, kr_wrap, g_wrap, c_wrap, r_wrap;
    logic            tap_n, plane_n;

`ifdef CONV_FEED_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Abort wins over a simultaneous handshake; counters stay at zero outside RUN.
    assign fire    = (state == RUN) && feat_ready && !abort_i;
    assign cnt_clr = (state != RUN) || abort_i;

    conv_feed_cnt #(.MAX(KW),        .W(KC_W)) u_kc (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(fire),    .value(kc), .wrap(kc_wrap));
    conv_feed_cnt #(.MAX(KH),        .W(KR_W)) u_kr (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(kc_wrap), .value(kr), .wrap(kr_wrap));
    conv_feed_cnt #(.MAX(CH_GROUPS), .W(G_W))  u_g  (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(kr_wrap), .value(g),  .wrap(g_wrap));
    conv_feed_cnt #(.MAX(OUT_COLS),  .W(C_W))  u_c  (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(g_wrap),  .value(c),  .wrap(c_wrap));
    conv_feed_cnt #(.MAX(OUT_ROWS),  .W(R_W))  u_r  (.clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(c_wrap),  .value(r),  .wrap(r_wrap));

    // Loop position of the beat presented next, so the tags can be registered.
    assign kc_n = kc_wrap ? '0 : (fire    ? kc + 1'b1 : kc);
    assign kr_n = kr_wrap ? '0 : (kc_wrap ? kr + 1'b1 : kr);
    assign g_n  = g_wrap  ? '0 : (kr_wrap ? g  + 1'b1 : g);
    assign c_n  = c_wrap  ? '0 : (g_wrap  ? c  + 1'b1 : c);
    assign r_n  = r_wrap  ? '0 : (c_wrap  ? r  + 1'b1 : r);

    assign tap_n   = (g_n == G_W'(CH_GROUPS - 1)) && (kr_n == KR_W'(KH - 1)) && (kc_n == KC_W'(KW - 1));
    assign plane_n = tap_n && (r_n == R_W'(OUT_ROWS - 1)) && (c_n == C_W'(OUT_COLS - 1));

    // Neuron base r*IN_COLS+c advances by one per column and jumps at row end.
    assign nbase_n = c_wrap ? nbase + ADDR_W'(STEP_NROW) : nbase + 1'b1;

    // Control FSM and all registered outputs; address follows incrementally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            feat_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tap_last   <= 1'b0;
            plane_last <= 1'b0;
            feat_addr  <= '0;
            out_addr   <= '0;
            nbase      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        feat_valid <= 1'b1;
                        feat_addr  <= ADDR_W'(BASE_ADDR);
                        out_addr   <= '0;
                        nbase      <= '0;
                        tap_last   <= tap_n;
                        plane_last <= plane_n;
                    end
                end
                RUN: begin
                    if (abort_i || r_wrap) begin
                        state      <= abort_i ? IDLE : DONE;
                        done       <= !abort_i;
                        busy       <= 1'b0;
                        feat_valid <= 1'b0;
                        tap_last   <= 1'b0;
                        plane_last <= 1'b0;
                        feat_addr  <= '0;
                        out_addr   <= '0;
                        nbase      <= '0;
                    end else if (fire) begin
                        tap_last   <= tap_n;
                        plane_last <= plane_n;
                        if (g_wrap) begin
                            nbase     <= nbase_n;
                            feat_addr <= ADDR_W'(BASE_ADDR) + nbase_n;
                            out_addr  <= out_addr + 1'b1;
                        end else if (kr_wrap) begin
                            feat_addr <= feat_addr + ADDR_W'(STEP_GRP);
                        end else if (kc_wrap) begin
                            feat_addr <= feat_addr + ADDR_W'(STEP_ROW);
                        end else begin
                            feat_addr <= feat_addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_feed_seq.sv
// Directed bench for conv_feed_seq with default geometry (5x5 kernel,
// one channel group, 28x28 output plane, 32x32 input plane).
module tb_conv_feed_seq;

    localparam int KH     = 5;
    localparam int KW     = 5;
    localparam int OC     = 28;
    localparam int IN_C   = 32;
    localparam int IN_R   = 32;
    localparam int TAPS   = 25;
    localparam int NBEATS = 19600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        feat_ready = 1'b0;
    logic        abort = 1'b0;
    logic        feat_valid;
    logic [15:0] feat_addr;
    logic        tap_last;
    logic        plane_last;
    logic [15:0] out_addr;
    logic        busy;
    logic        done;

    conv_feed_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef CONV_FEED_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .feat_ready (feat_ready),
        .feat_valid (feat_valid),
        .feat_addr  (feat_addr),
        .tap_last   (tap_last),
        .plane_last (plane_last),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int beat;
        int addr;
        bit tap;
        bit plane;
        int oa;
    } vec_t;

    vec_t vecs[11];

    int checks = 0;
    int errors = 0;
    int beat, fires, taps_seen, bulk_err, first_bad_beat, first_bad_addr, cyc, stall;
    bit plane_fired, stall_diff;
    logic [15:0] snap_addr, snap_oa;
    logic [1:0]  snap_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference address straight from the loop-nest formula.
    function automatic int m_addr(input int b);
        int n, t, r, c, g, kr, kc;
        n  = b / TAPS;
        t  = b % TAPS;
        r  = n / OC;
        c  = n % OC;
        g  = t / (KH * KW);
        kr = (t % (KH * KW)) / KW;
        kc = t % KW;
        return (g * IN_R * IN_C + (r + kr) * IN_C + c + kc) % 65536;
    endfunction

    // One clock: compare the presented beat with the model, then advance.
    task automatic cycle();
        bit f;
        if (feat_valid === 1'b1) begin
            if (feat_addr !== 16'(m_addr(beat)) ||
                tap_last !== 1'((beat % TAPS) == TAPS - 1) ||
                plane_last !== 1'(beat == NBEATS - 1) ||
                out_addr !== 16'(beat / TAPS)) begin
                if (bulk_err == 0) begin
                    first_bad_beat = beat;
                    first_bad_addr = int'(feat_addr);
                end
                bulk_err++;
            end
        end
        f = (feat_valid === 1'b1) && (feat_ready === 1'b1);
        if (f) begin
            fires++;
            if (tap_last === 1'b1) taps_seen++;
            if (plane_last === 1'b1) plane_fired = 1'b1;
        end
        @(posedge clk);
        #1;
        if (f) beat++;
    endtask

    task automatic clear_stats();
        beat = 0; fires = 0; taps_seen = 0; bulk_err = 0;
        first_bad_beat = 0; first_bad_addr = 0; plane_fired = 1'b0; cyc = 0;
    endtask

    task automatic report_bulk(input string name);
        checks++;
        if (bulk_err != 0) begin
            errors++;
            $display("FAIL %s: %0d bad beats, first at beat %0d got addr %0d, expected addr %0d",
                     name, bulk_err, first_bad_beat, first_bad_addr, m_addr(first_bad_beat));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0,     0,    1'b0, 1'b0, 0};
        vecs[1]  = '{1,     1,    1'b0, 1'b0, 0};
        vecs[2]  = '{4,     4,    1'b0, 1'b0, 0};
        vecs[3]  = '{5,     32,   1'b0, 1'b0, 0};
        vecs[4]  = '{6,     33,   1'b0, 1'b0, 0};
        vecs[5]  = '{24,    132,  1'b1, 1'b0, 0};
        vecs[6]  = '{25,    1,    1'b0, 1'b0, 1};
        vecs[7]  = '{49,    133,  1'b1, 1'b0, 1};
        vecs[8]  = '{675,   27,   1'b0, 1'b0, 27};
        vecs[9]  = '{700,   32,   1'b0, 1'b0, 28};
        vecs[10] = '{19599, 1023, 1'b1, 1'b1, 783};

        // Reset state
        feat_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_feat_valid", feat_valid, 0);
        check("rst_busy",       busy,       0);
        check("rst_done",       done,       0);
        check("rst_tap_last",   tap_last,   0);
        check("rst_plane_last", plane_last, 0);
        check("rst_feat_addr",  feat_addr,  0);
        check("rst_out_addr",   out_addr,   0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_start_valid", feat_valid, 0);

        // Full plane with feat_ready held high; extra start at beat 50
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy",  busy,       1);
        check("start_valid", feat_valid, 1);
        check("start_addr",  feat_addr,  0);
        clear_stats();
        while (!plane_fired && cyc < NBEATS + 100) begin
            for (int i = 0; i < 11; i++) begin
                if (vecs[i].beat == beat && feat_valid === 1'b1) begin
                    check($sformatf("vec%0d_addr", i),  feat_addr,  vecs[i].addr);
                    check($sformatf("vec%0d_tap", i),   tap_last,   vecs[i].tap);
                    check($sformatf("vec%0d_plane", i), plane_last, vecs[i].plane);
                    check($sformatf("vec%0d_oaddr", i), out_addr,   vecs[i].oa);
                end
            end
            start = (beat == 50);
            cycle();
            cyc++;
        end
        start = 1'b0;
        check("plane_completed", plane_fired, 1);
        check("plane_fires",     fires,       NBEATS);
        check("plane_tap_count", taps_seen,   784);
        check("plane_cycles",    cyc,         NBEATS);
        report_bulk("plane_sequence");
        check("done_pulse", done,       1);
        check("done_busy",  busy,       0);
        check("done_valid", feat_valid, 0);

        // start during the DONE cycle must not be queued
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("after_done_done",  done,       0);
        check("after_done_valid", feat_valid, 0);
        @(posedge clk);
        #1;
        check("done_start_ignored_valid", feat_valid, 0);
        check("done_start_ignored_busy",  busy,       0);

        // Backpressure: three stalled cycles at beat 10
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_addr", feat_addr, 0);
        clear_stats();
        stall = 0;
        stall_diff = 1'b0;
        while (beat < 100 && cyc < 300) begin
            if (beat == 10 && stall < 3) begin
                feat_ready = 1'b0;
                if (stall == 0) begin
                    snap_addr = feat_addr;
                    snap_tag  = {tap_last, plane_last};
                    snap_oa   = out_addr;
                end else if (feat_addr !== snap_addr || {tap_last, plane_last} !== snap_tag ||
                             out_addr !== snap_oa || feat_valid !== 1'b1) begin
                    stall_diff = 1'b1;
                end
                stall++;
            end else begin
                feat_ready = 1'b1;
            end
            cycle();
            cyc++;
        end
        check("stall_addr",   snap_addr,  64);
        check("stall_oaddr",  snap_oa,    0);
        check("stall_stable", stall_diff, 0);
        check("bp_fires",     fires,      100);
        check("bp_cycles",    cyc,        103);
        report_bulk("bp_sequence");

        // Asynchronous reset while beat 100 is presented
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", feat_valid, 0);
        check("arst_busy",  busy,       0);
        check("arst_done",  done,       0);
        check("arst_addr",  feat_addr,  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_idle_valid", feat_valid, 0);
        check("post_rst_idle_busy",  busy,       0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("post_rst_start_valid", feat_valid, 1);
        check("post_rst_start_addr",  feat_addr,  0);
        check("post_rst_start_oaddr", out_addr,   0);

`ifdef CONV_FEED_ABORT_EN
        // Abort coincident with a fire at beat 40
        clear_stats();
        feat_ready = 1'b1;
        while (beat < 40 && cyc < 100) begin
            cycle();
            cyc++;
        end
        check("abort_reached_beat", beat, 40);
        report_bulk("abort_prefix");
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_valid", feat_valid, 0);
        check("abort_busy",  busy,       0);
        check("abort_done",  done,       0);
        @(posedge clk);
        #1;
        check("abort_no_done_later", done,       0);
        check("abort_idle_valid",    feat_valid, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort_restart_valid", feat_valid, 1);
        check("abort_restart_addr",  feat_addr,  0);
        check("abort_restart_tap",   tap_last,   0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
